// File: rtl/ky32_regfile_sb.sv
// Register file with scoreboard: power-up clear sequence, two combinational read
// ports with optional writeback forwarding, and busy-bit issue interlock.
module ky32_regfile_sb #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned NREG   = 32,
  parameter bit          BYPASS = 1'b1,
  localparam int unsigned AW    = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic            clk,
  input  logic            rst,
  output logic            ready,
  input  logic [AW-1:0]   ra_addr,
  input  logic [AW-1:0]   rb_addr,
  output logic [XLEN-1:0] ra_data,
  output logic [XLEN-1:0] rb_data,
  input  logic            we,
  input  logic [AW-1:0]   w_addr,
  input  logic [XLEN-1:0] wd,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_rd,
  input  logic            flush,
  output logic            stall,
  output logic            iss_ack
);

  localparam logic [AW:0]   NREG_W = (AW+1)'(NREG);
  localparam logic [AW-1:0] LAST   = AW'(NREG - 1);

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t            state;
  logic [AW-1:0]     clr_cnt;
  logic [NREG-1:0]   busy;
  logic [NREG-1:0]   busy_nxt;
  logic [XLEN-1:0]   regs [NREG];
  logic              wb_live;
  logic              wr_en;
  logic [AW-1:0]     wr_idx;
  logic [XLEN-1:0]   wr_data;

  // Address 0 and addresses past the end of the array are inert.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (a != '0) && ({1'b0, a} < NREG_W);
  endfunction

  function automatic logic fwd(input logic [AW-1:0] a);
    return BYPASS && wb_live && (w_addr == a);
  endfunction

  function automatic logic busy_test(input logic [AW-1:0] a);
    return addr_ok(a) && busy[a] && !fwd(a);
  endfunction

  function automatic logic [XLEN-1:0] rd_port(input logic [AW-1:0] a);
    if (!ready || !addr_ok(a)) return '0;
    if (fwd(a)) return wd;
    return regs[a];
  endfunction

  assign wb_live = ready && we && addr_ok(w_addr);

  always_comb begin
    ra_data = rd_port(ra_addr);
    rb_data = rd_port(rb_addr);
  end

  // Issue interlock: RAW on either source, WAW on the destination.
  always_comb begin
    stall   = 1'b1;
    iss_ack = 1'b0;
    if (ready) begin
      stall   = iss_valid && (busy_test(ra_addr) || busy_test(rb_addr) || busy_test(iss_rd));
      iss_ack = iss_valid && !stall;
    end
  end

  // Issue set is applied after writeback clear so a same-edge set wins; flush beats both.
  always_comb begin
    busy_nxt = busy;
    if (flush) begin
      busy_nxt = '0;
    end else begin
      if (wb_live) busy_nxt[w_addr] = 1'b0;
      if (iss_ack && addr_ok(iss_rd)) busy_nxt[iss_rd] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  // Single array write port shared by the clear sequence and writeback.
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = clr_cnt;
    wr_data = '0;
    if (state == S_CLEAR) begin
      wr_en = 1'b1;
    end else if (wb_live) begin
      wr_en   = 1'b1;
      wr_idx  = w_addr;
      wr_data = wd;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) regs[wr_idx] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_CLEAR;
      clr_cnt <= AW'(1);
      ready   <= 1'b0;
      busy    <= '0;
    end else begin
      case (state)
        S_CLEAR: begin
          clr_cnt <= clr_cnt + AW'(1);
          if (clr_cnt == LAST) begin
            state <= S_RUN;
            ready <= 1'b1;
          end
        end
        S_RUN: busy <= busy_nxt;
        default: begin
          state <= S_CLEAR;
          ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/ky32_regfile_sb.md
KY32_REGFILE_SB -- requirements
Module: ky32_regfile_sb

Interface
REQ-001 Parameter XLEN, default 32, data width of every register and data port.
REQ-002 Parameter NREG, default 32, register count; AW = clog2(NREG) is the address width.
REQ-003 Parameter BYPASS, default 1, enables write-to-read forwarding and same-cycle busy masking (1) or disables both (0).
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 ready  output  1  high when the clear sequence has finished and the block accepts traffic.
REQ-007 ra_addr, rb_addr  input  AW  read-port A/B register addresses.
REQ-008 ra_data, rb_data  output  XLEN  read-port A/B data, combinational from address.
REQ-009 we  input  1  writeback strobe.
REQ-010 w_addr  input  AW  writeback register address.
REQ-011 wd  input  XLEN  writeback data.
REQ-012 iss_valid  input  1  an instruction requests issue with destination iss_rd.
REQ-013 iss_rd  input  AW  destination register of the issuing instruction.
REQ-014 flush  input  1  synchronous clear of all busy bits (pipeline squash).
REQ-015 stall  output  1  issue is blocked this cycle.
REQ-016 iss_ack  output  1  issue accepted this cycle; iss_rd is marked busy.

Function
REQ-017 Register 0 SHALL always read 0; writes, issue marks and busy bits for address 0 are ignored.
REQ-018 State machine: CLEAR and RUN; reset enters CLEAR with clear counter = 1.
REQ-019 CLEAR: each cycle writes 0 to register[counter] and increments; after writing NREG-1, go to RUN next edge; ready = (state == RUN).
REQ-020 The clear sequence therefore takes NREG-1 cycles; with NREG=32, ready rises on the 31st rising edge after rst deasserts.
REQ-021 While in CLEAR: ra_data = rb_data = 0, we/iss_valid/flush ignored, stall = 1, iss_ack = 0.
REQ-022 RUN write: we=1 and w_addr!=0 stores wd into register[w_addr] at the edge and clears busy[w_addr].
REQ-023 RUN read: data = register[addr]; if BYPASS=1 and we=1 and w_addr==addr!=0, data = wd in the same cycle.
REQ-024 Busy test per address x (x!=0): busy[x] and not (BYPASS=1 and we=1 and w_addr==x).
REQ-025 stall = iss_valid and (busy test true for ra_addr, rb_addr or iss_rd); stall = 0 when iss_valid = 0.
REQ-026 iss_ack = ready and iss_valid and not stall; on iss_ack with iss_rd!=0, busy[iss_rd] is set at the edge.
REQ-027 Same-edge writeback and issue to one register: set wins; busy stays 1 (new producer outstanding).
REQ-028 flush=1 clears all busy bits at the edge and takes priority over an issue set in that cycle; register writes in that cycle still occur.
REQ-029 Writeback to a non-busy register is legal: data is stored and busy stays 0.
REQ-030 Addresses >= NREG (non-power-of-two NREG) read 0, are never written, and never stall.

Reset
REQ-031 rst asserted: state = CLEAR, counter = 1, all busy bits = 0, ready = 0, iss_ack = 0 immediately, without a clock edge.
REQ-032 rst asserted mid-CLEAR or mid-RUN aborts the current operation; the full clear sequence restarts after deassertion.
REQ-033 Register array contents are zeroed only by the clear sequence, not by rst directly.

Verification
REQ-034 Reset, NREG=32: deassert rst, count edges -> ready=1 after exactly 31 edges; every register reads 0.
REQ-035 RUN, BYPASS=1: we=1, w_addr=5, wd=0xDEADBEEF, ra_addr=5 same cycle -> ra_data=0xDEADBEEF combinationally; next cycle still 0xDEADBEEF with we=0.
REQ-036 Issue iss_rd=7 (iss_ack=1), next cycle iss_valid with ra_addr=7 -> stall=1; writeback to 7 that cycle -> stall=0 (BYPASS=1) / stall=1 (BYPASS=0).
REQ-037 Same edge we to 9 and iss_ack with iss_rd=9 -> busy[9]=1 afterwards; iss_valid with rb_addr=9 stalls.
REQ-038 Registers 3, 4 busy, flush=1 -> next cycle no stall on 3 or 4; write x0=0x1234 -> ra_addr=0 reads 0, never stalls.
REQ-039 rst pulse at RUN with registers holding nonzero data -> ready=0 immediately, all registers 0 after re-clear, no busy bits set.
